// File: rtl/midi_voice_allocator_pkg.sv
// midi_voice_allocator_pkg: FSM state encodings, note-off velocity and default sizes shared by the allocator and the voice bank
package midi_voice_allocator_pkg;
  localparam int NUM_VOICES_DEF = 4;
  localparam int AGE_W_DEF = 4;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;
  localparam logic [1:0] APPLY = 2'd3;
  localparam logic [7:0] VEL_NOTE_OFF = 8'd0;
endpackage

// File: rtl/midi_voice_allocator_slot.sv
// midi_voice_slot: one voice's gate/key/velocity/age registers with load, release, ageing and panic clear
module midi_voice_slot
  import midi_voice_allocator_pkg::*;
#(
  parameter int AGE_W = AGE_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             rel_i,
  input  logic             inc_i,
  input  logic [7:0]       key_i,
  input  logic [7:0]       vel_i,
  output logic             gate_o,
  output logic [7:0]       key_o,
  output logic [7:0]       vel_o,
  output logic [AGE_W-1:0] age_o
);
  logic             gate_q;
  logic [7:0]       key_q;
  logic [7:0]       vel_q;
  logic [AGE_W-1:0] age_q;
  // panic wins; a load restarts the voice, otherwise release and saturating ageing apply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= 1'b0;
      key_q  <= '0;
      vel_q  <= '0;
      age_q  <= '0;
    end else if (clr_i) begin
      gate_q <= 1'b0;
      age_q  <= '0;
    end else if (load_i) begin
      gate_q <= 1'b1;
      key_q  <= key_i;
      vel_q  <= vel_i;
      age_q  <= '0;
    end else begin
      if (rel_i) gate_q <= 1'b0;
      if (inc_i && !(&age_q)) age_q <= age_q + 1'b1;
    end
  end
  assign gate_o = gate_q;
  assign key_o  = key_q;
  assign vel_o  = vel_q;
  assign age_o  = age_q;
endmodule

// File: rtl/midi_voice_allocator.sv
// midi_voice_allocator: drains FIFO note events into voice slots; define VOICE_STEAL_EN to steal the oldest voice when all are busy
module midi_voice_allocator
  import midi_voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int AGE_W      = AGE_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              fifo_key,
  input  logic [7:0]              fifo_velocity,
  input  logic                    fifo_empty,
  output logic                    fifo_rd,
  input  logic                    all_notes_off,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic [8*NUM_VOICES-1:0] voice_key,
  output logic [8*NUM_VOICES-1:0] voice_vel,
  output logic                    busy,
  output logic                    note_dropped
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
  logic [1:0]            state_q, state_d;
  logic [IW-1:0]         idx_q, match_idx_q, free_idx_q, old_idx_q, tgt;
  logic [7:0]            key_q, vel_q;
  logic                  match_q, free_q, old_q;
  logic [AGE_W-1:0]      old_age_q;
  logic [7:0]            slot_key [NUM_VOICES];
  logic [7:0]            slot_vel [NUM_VOICES];
  logic [AGE_W-1:0]      slot_age [NUM_VOICES];
  logic [NUM_VOICES-1:0] load, rel, inc;
  logic                  apply, note_on, has_tgt;
  logic                  cur_gate;
  assign state_d = all_notes_off ? IDLE :
                   (state_q == IDLE)  ? (fifo_empty ? IDLE : FETCH) :
                   (state_q == FETCH) ? (fifo_empty ? IDLE : SCAN) :
                   (state_q == SCAN)  ? ((idx_q == LAST) ? APPLY : SCAN) : IDLE;
  assign fifo_rd  = (state_q == FETCH) && !fifo_empty && !all_notes_off;
  assign busy     = state_q != IDLE;
  assign apply    = (state_q == APPLY) && !all_notes_off;
  assign note_on  = vel_q != VEL_NOTE_OFF;
  assign cur_gate = voice_gate[idx_q];
  assign tgt      = match_q ? match_idx_q : free_q ? free_idx_q : old_idx_q;
`ifdef VOICE_STEAL_EN
  assign has_tgt  = match_q || free_q || old_q;
`else
  assign has_tgt  = match_q || free_q;
`endif
  assign note_dropped = apply && note_on && !has_tgt;
  assign voice_trig   = load;
  // event sequencer; panic forces IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // latch the popped event, then walk the voices recording match, first free and oldest gated candidates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      vel_q       <= '0;
      idx_q       <= '0;
      match_q     <= 1'b0;
      free_q      <= 1'b0;
      old_q       <= 1'b0;
      match_idx_q <= '0;
      free_idx_q  <= '0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
    end else if (state_q == FETCH) begin
      key_q   <= fifo_key;
      vel_q   <= fifo_velocity;
      idx_q   <= '0;
      match_q <= 1'b0;
      free_q  <= 1'b0;
      old_q   <= 1'b0;
    end else if (state_q == SCAN) begin
      idx_q <= idx_q + 1'b1;
      if (!match_q && cur_gate && slot_key[idx_q] == key_q) begin
        match_q     <= 1'b1;
        match_idx_q <= idx_q;
      end
      if (!free_q && !cur_gate) begin
        free_q     <= 1'b1;
        free_idx_q <= idx_q;
      end
      if (cur_gate && (!old_q || slot_age[idx_q] > old_age_q)) begin
        old_q     <= 1'b1;
        old_idx_q <= idx_q;
        old_age_q <= slot_age[idx_q];
      end
    end
  end
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    assign load[i] = apply && note_on && has_tgt && tgt == IW'(i);
    assign inc[i]  = apply && note_on && has_tgt && tgt != IW'(i) && voice_gate[i];
    assign rel[i]  = apply && !note_on && voice_gate[i] && slot_key[i] == key_q;
    midi_voice_slot #(.AGE_W(AGE_W)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (all_notes_off),
      .load_i (load[i]),
      .rel_i  (rel[i]),
      .inc_i  (inc[i]),
      .key_i  (key_q),
      .vel_i  (vel_q),
      .gate_o (voice_gate[i]),
      .key_o  (slot_key[i]),
      .vel_o  (slot_vel[i]),
      .age_o  (slot_age[i])
    );
    assign voice_key[8*i +: 8] = slot_key[i];
    assign voice_vel[8*i +: 8] = slot_vel[i];
  end
endmodule

// File: tb/tb_midi_voice_allocator.sv
// tb_midi_voice_allocator: directed checks of allocation, release, retrigger, full-bank handling, panic and back-to-back draining
module tb_midi_voice_allocator;
  localparam int NV = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic all_notes_off = 1'b0;
  logic [7:0] fifo_key, fifo_velocity;
  logic fifo_empty, fifo_rd, busy, note_dropped;
  logic [NV-1:0] voice_gate, voice_trig;
  logic [8*NV-1:0] voice_key, voice_vel;
  logic [15:0] ev [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pass_cnt = 0;
  int total = 0;
  int rd_cnt = 0;
  int rd_bad = 0;
  int drop_cnt = 0;
  int gap = 0;
  int max_gap = 0;
  logic [NV-1:0] trig_acc = '0;
  logic trig_clr = 1'b0;
  logic pend = 1'b0;
  logic mon = 1'b0;
  int base;
  int dbase;

  midi_voice_allocator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_key      (fifo_key),
    .fifo_velocity (fifo_velocity),
    .fifo_empty    (fifo_empty),
    .fifo_rd       (fifo_rd),
    .all_notes_off (all_notes_off),
    .voice_gate    (voice_gate),
    .voice_trig    (voice_trig),
    .voice_key     (voice_key),
    .voice_vel     (voice_vel),
    .busy          (busy),
    .note_dropped  (note_dropped)
  );

  always #5 clk = ~clk;

  assign fifo_empty    = rd_ptr == wr_ptr;
  assign fifo_key      = ev[rd_ptr[5:0]][15:8];
  assign fifo_velocity = ev[rd_ptr[5:0]][7:0];

  always @(negedge clk) begin
    if (pend) rd_ptr = rd_ptr + 1;
    pend = 1'b0;
    if (fifo_rd) begin
      rd_cnt++;
      if (fifo_empty) rd_bad++;
      pend = 1'b1;
    end
    if (trig_clr) trig_acc = '0;
    trig_acc = trig_acc | voice_trig;
    if (note_dropped) drop_cnt++;
    if (mon) begin
      gap = busy ? 0 : gap + 1;
      if (gap > max_gap) max_gap = gap;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [7:0] k, input logic [7:0] v);
    ev[wr_ptr[5:0]] = {k, v};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic clear_trig();
    trig_clr = 1'b1;
    @(negedge clk);
    trig_clr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while ((rd_cnt < target || busy || pend || !fifo_empty) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 400), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    chk("rst_gate", 32'(voice_gate), 32'd0);
    chk("rst_trig", 32'(voice_trig), 32'd0);
    chk("rst_key", voice_key, 32'd0);
    chk("rst_vel", voice_vel, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(note_dropped), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // 1: single note-on, cycle-exact latency
    push(8'h45, 8'h55);
    @(negedge clk);
    chk("t1_rd_fetch", 32'(fifo_rd), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_rd_scan", 32'(fifo_rd), 32'd0);
    repeat (4) @(negedge clk);
    chk("t1_trig_apply", 32'(voice_trig), 32'h1);
    chk("t1_gate_pre", 32'(voice_gate), 32'h0);
    @(negedge clk);
    chk("t1_gate", 32'(voice_gate), 32'h1);
    chk("t1_key", 32'(voice_key[7:0]), 32'h45);
    chk("t1_vel", 32'(voice_vel[7:0]), 32'h55);
    chk("t1_trig_off", 32'(voice_trig), 32'h0);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_rdcnt", rd_cnt, 32'd1);
    // 2: second voice, then note-off of the first
    push(8'h30, 8'h40);
    push(8'h45, 8'h00);
    wait_done("t2", 3);
    chk("t2_gate", 32'(voice_gate), 32'h2);
    chk("t2_key0", 32'(voice_key[7:0]), 32'h45);
    chk("t2_key1", 32'(voice_key[15:8]), 32'h30);
    chk("t2_vel1", 32'(voice_vel[15:8]), 32'h40);
    // 3: retrigger held key, then unmatched note-off
    clear_trig();
    push(8'h30, 8'h7F);
    wait_done("t3", 4);
    chk("t3_gate", 32'(voice_gate), 32'h2);
    chk("t3_vel1", 32'(voice_vel[15:8]), 32'h7F);
    chk("t3_trig", 32'(trig_acc), 32'h2);
    chk("t3_v0", {voice_key[7:0], voice_vel[7:0]}, 32'h4555);
    clear_trig();
    push(8'h77, 8'h00);
    wait_done("t3b", 5);
    chk("t3b_gate", 32'(voice_gate), 32'h2);
    chk("t3b_trig", 32'(trig_acc), 32'h0);
    // 4: full bank, then one more note-on
    push(8'h30, 8'h00);
    push(8'h10, 8'h01);
    push(8'h11, 8'h02);
    push(8'h12, 8'h03);
    push(8'h13, 8'h04);
    wait_done("t4fill", 10);
    chk("t4_fill_gate", 32'(voice_gate), 32'hF);
    chk("t4_fill_key", voice_key, 32'h13121110);
    clear_trig();
    dbase = drop_cnt;
    push(8'h20, 8'h66);
    wait_done("t4", 11);
    chk("t4_gate", 32'(voice_gate), 32'hF);
`ifdef VOICE_STEAL_EN
    chk("t4_key", voice_key, 32'h13121120);
    chk("t4_vel0", 32'(voice_vel[7:0]), 32'h66);
    chk("t4_trig", 32'(trig_acc), 32'h1);
    chk("t4_drop", drop_cnt - dbase, 32'd0);
`else
    chk("t4_key", voice_key, 32'h13121110);
    chk("t4_vel", voice_vel, 32'h04030201);
    chk("t4_trig", 32'(trig_acc), 32'h0);
    chk("t4_drop", drop_cnt - dbase, 32'd1);
`endif
    // 5: panic during SCAN
    push(8'h50, 8'h70);
    @(negedge clk);
    chk("t5_rd", 32'(fifo_rd), 32'd1);
    @(negedge clk);
    all_notes_off = 1'b1;
    @(negedge clk);
    chk("t5_gate", 32'(voice_gate), 32'h0);
    chk("t5_busy", 32'(busy), 32'd0);
    base = rd_cnt;
    push(8'h51, 8'h71);
    repeat (5) @(negedge clk);
    chk("t5_nord", rd_cnt - base, 32'd0);
    chk("t5_hold", 32'(busy), 32'd0);
    all_notes_off = 1'b0;
    wait_done("t5", base + 1);
    chk("t5_gate_after", 32'(voice_gate), 32'h1);
    chk("t5_key_after", 32'(voice_key[7:0]), 32'h51);
    // 6: six back-to-back events
    all_notes_off = 1'b1;
    @(negedge clk);
    all_notes_off = 1'b0;
    base = rd_cnt;
    dbase = drop_cnt;
    max_gap = 0;
    gap = 0;
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i), 8'(i + 1));
    mon = 1'b1;
    wait_done("t6", base + 6);
    mon = 1'b0;
    chk("t6_rdcnt", rd_cnt - base, 32'd6);
    chk("t6_gap", 32'(max_gap <= 1), 32'd1);
    chk("t6_gate", 32'(voice_gate), 32'hF);
`ifdef VOICE_STEAL_EN
    chk("t6_key", voice_key, 32'h63626564);
    chk("t6_drop", drop_cnt - dbase, 32'd0);
`else
    chk("t6_key", voice_key, 32'h63626160);
    chk("t6_drop", drop_cnt - dbase, 32'd2);
`endif
    chk("rd_never_empty", rd_bad, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
